// File: rtl/mnist_pkg.sv
// Shared types and sizes for the MNIST sample feeder.
package mnist_pkg;

  localparam int NPIX       = 784;
  localparam int NFEAT      = 14;
  localparam int IDX_W      = 10;
  localparam int RESULT_LAT = 1;
  localparam int CNT_W      = 32;
  localparam int ADDR_W     = 4;
  // Drain counter must reach RESULT_LAT
  localparam int DRAIN_W    = $clog2(RESULT_LAT + 2);

  typedef logic [NPIX:0]    mnist_rec_t;
  typedef logic [IDX_W-1:0] feat_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_TEST,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/feature_gather.sv
// NFEAT-way pixel mux: each feature slot picks one pixel of the record.
// Index 0 addresses the label bit and indices past NPIX are out of range,
// so both read as 0. Kept combinational and standalone so a register
// stage can be dropped in later without touching the feeder.
module feature_gather
  import mnist_pkg::*;
(
  input  mnist_rec_t              rec_i,
  input  feat_idx_t [NFEAT-1:0]   tbl_i,
  output logic      [NFEAT-1:0]   x_o
);

  for (genvar i = 0; i < NFEAT; i++) begin : g_lane
    assign x_o[i] = (tbl_i[i] != '0 && tbl_i[i] <= IDX_W'(NPIX)) ? rec_i[tbl_i[i]] : 1'b0;
  end

endmodule

// File: rtl/mnist_sample_feeder.sv
// Feeds MNIST records to the learner as (x, y) pairs and, in test
// phase, scores the learner's delayed prediction against the label.
module mnist_sample_feeder
  import mnist_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  n_samples_i,
  input  logic              cfg_we_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [NPIX:0]     s_data_i,
  output logic [NFEAT-1:0]  x_o,
  output logic              y_o,
  output logic              x_valid_o,
  output logic              train_en_o,
  input  logic              result_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sample_cnt_o,
  output logic [CNT_W-1:0]  correct_cnt_o
);

  feeder_state_e         state_q, state_d;
  feat_idx_t [NFEAT-1:0] tbl_q;
  logic [CNT_W-1:0]      n_q;
  logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]      correct_cnt_q, correct_cnt_d;
  logic [NFEAT-1:0]      x_q;
  logic                  y_q;
  logic                  x_valid_q;
  // Label tag per entry: bit1 = x_valid, bit0 = label
  logic [RESULT_LAT-1:0][1:0] tag_q;
  logic [DRAIN_W-1:0]    drain_q;

  logic [NFEAT-1:0]      x_gather;
  logic                  start_ok;
  logic                  hs;
  logic                  all_in;
  logic                  score;

  assign start_ok = start_i && (state_q == ST_IDLE);
  assign hs       = s_valid_i && s_ready_o;
  assign all_in   = (sample_cnt_q >= n_q);
  // The oldest tag lines up with the result of the same record
  assign score    = ((state_q == ST_TEST) || (state_q == ST_DRAIN)) &&
                    tag_q[RESULT_LAT-1][1] && (result_i == tag_q[RESULT_LAT-1][0]);

  feature_gather u_gather (
    .rec_i (s_data_i),
    .tbl_i (tbl_q),
    .x_o   (x_gather)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a run ends one cycle after the last x_valid in train,
  // and after a RESULT_LAT+1 drain in test so the last result is scored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = (n_samples_i == '0) ? ST_DONE :
                                       (mode_i ? ST_TEST : ST_TRAIN);
      ST_TRAIN: if (all_in) state_d = ST_DONE;
      ST_TEST:  if (all_in) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DRAIN_W'(RESULT_LAT)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    s_ready_o  = 1'b0;
    busy_o     = 1'b0;
    train_en_o = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_TRAIN: begin
        busy_o     = 1'b1;
        train_en_o = 1'b1;
        s_ready_o  = (sample_cnt_q < n_q);
      end
      ST_TEST: begin
        busy_o    = 1'b1;
        s_ready_o = (sample_cnt_q < n_q);
      end
      ST_DRAIN: busy_o = 1'b1;
      ST_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Counter next-state: clear on a real start, saturate instead of wrapping
  always_comb begin
    sample_cnt_d  = sample_cnt_q;
    correct_cnt_d = correct_cnt_q;
    if (start_ok) begin
      sample_cnt_d  = '0;
      correct_cnt_d = '0;
    end else begin
      if (hs && sample_cnt_q != '1)     sample_cnt_d  = sample_cnt_q + CNT_W'(1);
      if (score && correct_cnt_q != '1) correct_cnt_d = correct_cnt_q + CNT_W'(1);
    end
  end

  // Datapath: feature table, x/y capture, label delay line, drain timer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NFEAT; i++) tbl_q[i] <= feat_idx_t'(i + 1);
      n_q           <= '0;
      sample_cnt_q  <= '0;
      correct_cnt_q <= '0;
      x_q           <= '0;
      y_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      tag_q         <= '0;
      drain_q       <= '0;
    end else begin
      sample_cnt_q  <= sample_cnt_d;
      correct_cnt_q <= correct_cnt_d;
      x_valid_q     <= hs;
      if (hs) begin
        x_q <= x_gather;
        y_q <= s_data_i[0];
      end
      if (start_ok) n_q <= n_samples_i;
      // Table write lands on the same edge as a start, so record 0 sees it
      if (state_q == ST_IDLE && cfg_we_i && cfg_addr_i < ADDR_W'(NFEAT))
        tbl_q[cfg_addr_i] <= cfg_idx_i;
      if (start_ok) begin
        tag_q <= '0;
      end else begin
        tag_q[0] <= {x_valid_q, y_q};
        for (int i = 1; i < RESULT_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
      drain_q <= (state_q == ST_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign x_valid_o     = x_valid_q;
  assign sample_cnt_o  = sample_cnt_q;
  assign correct_cnt_o = correct_cnt_q;

endmodule

// File: tb/tb_mnist_sample_feeder.sv
// Self-checking bench for mnist_sample_feeder: randomized records and
// handshakes against a cycle-level reference built from the feeder rules.
module tb_mnist_sample_feeder;
  import mnist_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, mode, cfg_we, s_valid, s_ready, y, x_valid;
  logic              train_en, result, busy, done;
  logic [CNT_W-1:0]  n_samples, sample_cnt, correct_cnt;
  logic [ADDR_W-1:0] cfg_addr;
  logic [IDX_W-1:0]  cfg_idx;
  logic [NPIX:0]     s_data;
  logic [NFEAT-1:0]  x;

  int               n_chk = 0;
  int               n_fail = 0;
  int               tbl_m[NFEAT];
  logic [NFEAT-1:0] exp_x;
  logic             exp_y;

  mnist_sample_feeder dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .n_samples_i(n_samples),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_idx_i(cfg_idx),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .x_o(x), .y_o(y), .x_valid_o(x_valid), .train_en_o(train_en), .result_i(result),
    .busy_o(busy), .done_o(done), .sample_cnt_o(sample_cnt), .correct_cnt_o(correct_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NFEAT-1:0] gather(mnist_rec_t r);
    logic [NFEAT-1:0] g = '0;
    for (int i = 0; i < NFEAT; i++)
      if (tbl_m[i] >= 1 && tbl_m[i] <= NPIX) g[i] = r[tbl_m[i]];
    return g;
  endfunction

  // sel 0: random; 1: pixels 1,3 set, labels 1,0,1..; 2: random with pixel 784 set;
  // 3: random, labels 1,1,0,0
  function automatic mnist_rec_t make_rec(int sel, int nacc);
    mnist_rec_t r;
    for (int i = 0; i <= NPIX; i++) r[i] = 1'($urandom_range(1, 0));
    case (sel)
      1: begin r = '0; r[1] = 1'b1; r[3] = 1'b1; r[0] = (nacc % 2 == 0); end
      2: r[NPIX] = 1'b1;
      3: r[0] = (nacc < 2);
      default: ;
    endcase
    return r;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; n_samples = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_idx = '0; s_valid = 1'b0; s_data = '0; result = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NFEAT; i++) tbl_m[i] = i + 1;
    exp_x = '0; exp_y = 1'b0;
  endtask

  task automatic cfg_write(input int slot, input int idx);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(slot); cfg_idx = IDX_W'(idx);
    @(posedge clk); #1 cfg_we = 1'b0;
    tbl_m[slot] = idx;
  endtask

  // One run from IDLE to the cycle after done, checked every cycle.
  // vpat 0: s_valid always, 1: alternating 1,0,.., 2: random.
  // rpol 0: learner always answers 1, 1: random answers.
  task automatic do_run(input bit md, input int n, input int vpat, input int recsel,
                        input int rpol, input bit cfg_at_start);
    int acc = 0, k, d, correct_m = 0;
    bit hs, hs_prev = 1'b0, exp_xv, exp_rdy, r;
    mnist_rec_t cur, prev = '0;
    bit xvh[0:511];
    bit lh[0:511];
    start = 1'b1; mode = md; n_samples = CNT_W'(n); s_valid = 1'b0;
    if (cfg_at_start) begin
      int sl, ix;
      sl = $urandom_range(NFEAT-1, 0); ix = $urandom_range(1023, 0);
      cfg_we = 1'b1; cfg_addr = ADDR_W'(sl); cfg_idx = IDX_W'(ix); tbl_m[sl] = ix;
    end
    @(posedge clk); #1 start = 1'b0; cfg_we = 1'b0;
    d = (n == 0) ? 1 : 32'h7fff_ffff;
    k = 1;
    while (k <= d) begin
      if (k > 400) begin
        n_chk++; n_fail++;
        $display("FAIL run_timeout: no done after %0d cycles, required within n=%0d run", k, n);
        break;
      end
      exp_xv = hs_prev;
      if (hs_prev) begin exp_x = gather(prev); exp_y = prev[0]; end
      exp_rdy = (k < d) && (acc < n);
      n_chk++; if (x_valid !== exp_xv) begin n_fail++; $display("FAIL x_valid k=%0d got %b want %b", k, x_valid, exp_xv); end
      n_chk++; if (x !== exp_x) begin n_fail++; $display("FAIL x k=%0d got %b want %b", k, x, exp_x); end
      n_chk++; if (y !== exp_y) begin n_fail++; $display("FAIL y k=%0d got %b want %b", k, y, exp_y); end
      n_chk++; if (s_ready !== exp_rdy) begin n_fail++; $display("FAIL s_ready k=%0d got %b want %b", k, s_ready, exp_rdy); end
      n_chk++; if (busy !== (k < d)) begin n_fail++; $display("FAIL busy k=%0d got %b want %b", k, busy, k < d); end
      n_chk++; if (done !== (k == d)) begin n_fail++; $display("FAIL done k=%0d got %b want %b", k, done, k == d); end
      n_chk++; if (train_en !== (k < d && !md)) begin n_fail++; $display("FAIL train_en k=%0d got %b want %b", k, train_en, k < d && !md); end
      n_chk++; if (sample_cnt !== CNT_W'(acc)) begin n_fail++; $display("FAIL sample_cnt k=%0d got %0d want %0d", k, sample_cnt, acc); end
      if (k == d) begin
        n_chk++; if (correct_cnt !== CNT_W'(correct_m)) begin n_fail++; $display("FAIL correct_cnt at done got %0d want %0d", correct_cnt, correct_m); end
      end
      // inputs for cycle k
      cur = make_rec(recsel, acc);
      s_data = cur;
      case (vpat)
        0: s_valid = 1'b1;
        1: s_valid = (k % 2 == 1);
        default: s_valid = 1'($urandom_range(1, 0));
      endcase
      xvh[k] = exp_xv; lh[k] = exp_y;
      if (k > RESULT_LAT && xvh[k-RESULT_LAT]) begin
        r = rpol ? 1'($urandom_range(1, 0)) : 1'b1;
        if (md && r == lh[k-RESULT_LAT]) correct_m++;
      end else begin
        r = 1'($urandom_range(1, 0));
      end
      result = r;
      // stray control traffic while not IDLE must be ignored
      start = ($urandom_range(7, 0) == 0); mode = 1'($urandom); n_samples = CNT_W'($urandom);
      cfg_we = ($urandom_range(3, 0) == 0); cfg_addr = ADDR_W'($urandom_range(NFEAT-1, 0));
      cfg_idx = IDX_W'($urandom);
      hs = s_valid && exp_rdy;
      if (hs) begin
        acc++; prev = cur;
        if (acc == n) d = k + 2 + (md ? RESULT_LAT + 1 : 0);
      end
      hs_prev = hs;
      @(posedge clk); #1 k++;
    end
    start = 1'b0; cfg_we = 1'b0; s_valid = 1'b0;
    n_chk++; if ({done, busy, x_valid, s_ready} !== 4'b0) begin n_fail++; $display("FAIL idle_after_run got done/busy/xv/rdy=%b want 0000", {done, busy, x_valid, s_ready}); end
    n_chk++; if (sample_cnt !== CNT_W'(acc)) begin n_fail++; $display("FAIL sample_cnt_hold got %0d want %0d", sample_cnt, acc); end
    n_chk++; if (correct_cnt !== CNT_W'(correct_m)) begin n_fail++; $display("FAIL correct_cnt_hold got %0d want %0d", correct_cnt, correct_m); end
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if ({x, y, x_valid, train_en, busy, done, s_ready, sample_cnt, correct_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got x=%b y=%b xv=%b te=%b busy=%b done=%b rdy=%b sc=%0d cc=%0d want all 0",
                         x, y, x_valid, train_en, busy, done, s_ready, sample_cnt, correct_cnt);
    end
  endtask

  task automatic test_train_basic();
    do_run(1'b0, 3, 0, 1, 0, 1'b0);
    n_chk++; if (x !== 14'b00000000000101) begin n_fail++; $display("FAIL train_basic_x got %b want 00000000000101", x); end
    n_chk++; if (y !== 1'b1) begin n_fail++; $display("FAIL train_basic_y got %b want 1", y); end
  endtask

  task automatic test_cfg_table();
    cfg_write(0, 784);
    cfg_write(1, 0);
    do_run(1'b0, 4, 0, 2, 0, 1'b0);
    n_chk++; if (x[1:0] !== 2'b01) begin n_fail++; $display("FAIL cfg_slots x[1:0] got %b want 01", x[1:0]); end
    cfg_write(2, 900);
    cfg_write(3, 1023);
    cfg_write(4, 785);
    cfg_write(5, 0);
    do_run(1'b0, 5, 2, 0, 0, 1'b1);
  endtask

  task automatic test_test_mode();
    do_run(1'b1, 4, 0, 3, 0, 1'b0);
    n_chk++; if (correct_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL test_mode_correct got %0d want 2", correct_cnt); end
  endtask

  task automatic test_gaps();
    do_run(1'b0, 4, 1, 0, 0, 1'b0);
    do_run(1'b1, 4, 1, 0, 1, 1'b0);
  endtask

  task automatic test_zero_samples();
    do_run(1'b0, 0, 0, 0, 0, 1'b0);
    do_run(1'b1, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    cfg_write(0, 500);
    start = 1'b1; mode = 1'b1; n_samples = CNT_W'(5);
    @(posedge clk); #1 start = 1'b0;
    repeat (2) begin
      s_valid = 1'b1; s_data = make_rec(0, 0);
      @(posedge clk); #1;
    end
    n_chk++; if (sample_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL mid_run_count got %0d want 2", sample_cnt); end
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    n_chk++;
    if ({x, y, x_valid, train_en, busy, done, s_ready, sample_cnt, correct_cnt} !== '0) begin
      n_fail++; $display("FAIL mid_run_reset got x=%b y=%b xv=%b te=%b busy=%b done=%b rdy=%b sc=%0d cc=%0d want all 0",
                         x, y, x_valid, train_en, busy, done, s_ready, sample_cnt, correct_cnt);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL no_done_after_abort got done/busy=%b want 00", {done, busy}); end
    end
    for (int i = 0; i < NFEAT; i++) tbl_m[i] = i + 1;
    exp_x = '0; exp_y = 1'b0;
    do_run(1'b0, 3, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(1, 0) == 1) cfg_write($urandom_range(NFEAT-1, 0), $urandom_range(1023, 0));
      do_run(1'($urandom), $urandom_range(20, 1), 2, 0, 1, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    do_run(1'b1, 6, 0, 0, 1, 1'b0);
    do_run(1'b0, 6, 0, 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_train_basic();
    test_cfg_table();
    test_test_mode();
    test_gaps();
    test_zero_samples();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
